sar_logic_cs_param: RTL and testbench
=====================================

SAR_LOGIC_CS_PARAM -- requirements
Module: sar_logic_cs_param

Interface
REQ-001 Parameter N, default 10: total resolution in bits; legal range 4..16.
REQ-002 Parameter K, default 5: coarse-stage bits; legal range 1..N-1.
REQ-003 Parameter TS, default 2: sample-phase length in clk cycles; minimum 1.
REQ-004 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port cnvst, input, 1: conversion start, level-sensitive.
REQ-007 Port cmp_out, input, 1: fine comparator decision.
REQ-008 Port cmp_out_coarse, input, 1: coarse comparator decision.
REQ-009 Port sar, output, N: last completed conversion result.
REQ-010 Port eoc, output, 1: end-of-conversion pulse.
REQ-011 Port cmp_clk / cmp_clk_coarse, output, 1 each: fine and coarse comparator clocks.
REQ-012 Port s_clk, output, 1: bootstrap sampling switch clock.
REQ-013 Port fine_btm, output, 2N: fine DAC bottom-plate controls, {P[N-1:0], N[N-1:0]}.
REQ-014 Port coarse_btm, output, 2K: coarse DAC bottom-plate controls, {P[K-1:0], N[K-1:0]}.
REQ-015 Port fine_switch_drain / coarse_switch_drain, output, 1 each: DAC drain enables.
REQ-016 Ports s_clk_not, fine_btm_not, coarse_btm_not, fine_switch_drain_not, coarse_switch_drain_not, output, same widths: bitwise complements of their counterparts.

Function
REQ-017 FSM states SHALL be IDLE, SAMPLE, COARSE, FINE, DONE.
REQ-018 IDLE->SAMPLE when cnvst=1 at a rising edge (edge E0); otherwise remain in IDLE.
REQ-019 SAMPLE: s_clk=1, all btm bits=0, both drains=0; lasts exactly TS cycles, then COARSE.
REQ-020 Each bit decision takes 2 cycles: phase A with comparator clock=1, decision latched at the edge ending phase A; phase B with comparator clock=0.
REQ-021 COARSE: coarse_switch_drain=1; resolves sar bits N-1..N-K MSB-first from cmp_out_coarse; for decision d on coarse bit j: P[j]<=~d, N[j]<=d.
REQ-022 At COARSE->FINE, the K coarse decisions SHALL be copied into fine_btm P/N bits N-1..N-K in the same edge.
REQ-023 FINE: fine_switch_drain=1; resolves bits N-K-1..0 from cmp_out using the same P/N rule on fine_btm.
REQ-024 sar SHALL update only on entry to DONE; it holds the previous result during a conversion.
REQ-025 eoc SHALL be high for exactly one cycle: the cycle following edge E0+TS+2N.
REQ-026 DONE->SAMPLE if cnvst=1 (continuous mode, no IDLE cycle); DONE->IDLE otherwise.
REQ-027 cnvst changes during SAMPLE, COARSE and FINE SHALL be ignored.
REQ-028 All outputs except the _not complements SHALL be registered; the complements are combinational.

Reset
REQ-029 While rst=1: state=IDLE; sar, eoc, cmp_clk, cmp_clk_coarse, s_clk, fine_btm, coarse_btm and both drains=0; all _not outputs=1.
REQ-030 Reset asserted mid-conversion SHALL abort immediately; the partial result is discarded and no eoc is generated.

Structure
REQ-031 Package sar_logic_pkg SHALL hold the state enum and the phase encoding constants.
REQ-032 One sub-module, sar_btm_switch_reg (parametrised width, bit index, decision, clear), SHALL be used for both the coarse and fine bottom-plate arrays.

Verification
REQ-033 N=10, K=5, TS=2; cnvst=1 held, cmp_out_coarse=1, cmp_out=0 -> sar=10'b1111100000; eoc pulse one cycle after edge E0+22.
REQ-034 Alternating decisions 1,0,1,... on both comparators -> sar=10'b1010101010; fine_btm P=10'b0101010101, N=10'b1010101010.
REQ-035 cnvst held high -> back-to-back conversions with eoc period of exactly TS+2N+1 cycles.
REQ-036 rst pulsed during FINE bit 2 -> all outputs at reset values immediately, no eoc; next cnvst yields a full correct conversion.
REQ-037 N=8, K=3, TS=4 -> eoc one cycle after edge E0+20; coarse_btm width 6, drains mutually exclusive throughout.
REQ-038 Continuous check: every _not output equals the complement of its counterpart in every cycle.

Source files
------------

// File: rtl/sar_logic_cs_param_pkg.sv
// Shared types for the coarse/fine SAR controller: FSM state encoding,
// bit-decision phase constants and a width helper.
package sar_logic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      COARSE = 3'd2,
      FINE   = 3'd3,
      DONE   = 3'd4
   } sar_state_e;

   // Each bit decision is two cycles: comparator clocked high, then low.
   localparam logic PH_A = 1'b0;
   localparam logic PH_B = 1'b1;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/sar_logic_cs_param_if.sv
// Signal bundle between the SAR controller and its analog front end.
// cnvst is a level request sampled in IDLE/DONE; eoc is a one-cycle completion strobe
// with sar valid from that cycle onwards (no ready/back-pressure exists).
interface sar_logic_cs_param_if #(
   parameter int N = 10,
   parameter int K = 5
);
   logic             cnvst;
   logic             cmp_out;
   logic             cmp_out_coarse;
   logic [N-1:0]     sar;
   logic             eoc;
   logic             cmp_clk;
   logic             cmp_clk_coarse;
   logic             s_clk;
   logic             s_clk_not;
   logic [2*N-1:0]   fine_btm;
   logic [2*N-1:0]   fine_btm_not;
   logic [2*K-1:0]   coarse_btm;
   logic [2*K-1:0]   coarse_btm_not;
   logic             fine_switch_drain;
   logic             fine_switch_drain_not;
   logic             coarse_switch_drain;
   logic             coarse_switch_drain_not;

   modport master (
      output cnvst, cmp_out, cmp_out_coarse,
      input  sar, eoc, cmp_clk, cmp_clk_coarse, s_clk, s_clk_not,
             fine_btm, fine_btm_not, coarse_btm, coarse_btm_not,
             fine_switch_drain, fine_switch_drain_not,
             coarse_switch_drain, coarse_switch_drain_not
   );

   modport slave (
      input  cnvst, cmp_out, cmp_out_coarse,
      output sar, eoc, cmp_clk, cmp_clk_coarse, s_clk, s_clk_not,
             fine_btm, fine_btm_not, coarse_btm, coarse_btm_not,
             fine_switch_drain, fine_switch_drain_not,
             coarse_switch_drain, coarse_switch_drain_not
   );
endinterface

// File: rtl/sar_logic_cs_param_btm_switch_reg.sv
// Bottom-plate switch register array {P[W-1:0], N[W-1:0]}: clear, single-bit
// decision write (P=~d, N=d) and a masked bulk load of decisions.
module sar_btm_switch_reg
   import sar_logic_pkg::*;
#(
   parameter int W  = 5,
   parameter int IW = clog2_min1(W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear_i,
   input  logic           set_i,
   input  logic [IW-1:0]  idx_i,
   input  logic           dec_i,
   input  logic           load_i,
   input  logic [W-1:0]   load_mask_i,
   input  logic [W-1:0]   load_dec_i,
   output logic [2*W-1:0] btm_o
);

   logic [W-1:0] p_q, p_d;
   logic [W-1:0] n_q, n_d;

   always_comb begin
      p_d = p_q;
      n_d = n_q;
      if (clear_i) begin
         p_d = '0;
         n_d = '0;
      end else begin
         if (load_i) begin
            p_d = (p_q & ~load_mask_i) | (~load_dec_i & load_mask_i);
            n_d = (n_q & ~load_mask_i) | (load_dec_i & load_mask_i);
         end
         if (set_i) begin
            p_d[idx_i] = ~dec_i;
            n_d[idx_i] = dec_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q <= '0;
         n_q <= '0;
      end else begin
         p_q <= p_d;
         n_q <= n_d;
      end
   end

   assign btm_o = {p_q, n_q};

endmodule

// File: rtl/sar_logic_cs_param.sv
// Coarse/fine SAR controller: sample for TS cycles, resolve K MSBs on the coarse
// comparator, hand them to the fine DAC, resolve the remaining bits, report.
module sar_logic_cs_param
   import sar_logic_pkg::*;
#(
   parameter int N  = 10,
   parameter int K  = 5,
   parameter int TS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sar_logic_cs_param_if.slave  bus,
   output sar_state_e           dbg_state_o
);

   localparam int BW = clog2_min1(N);
   localparam int CW = clog2_min1(K);
   localparam int TW = clog2_min1(TS);
   localparam logic [BW-1:0] MSB_IDX    = BW'(N - 1);
   localparam logic [BW-1:0] COARSE_LSB = BW'(N - K);
   localparam logic [BW-1:0] FINE_MSB   = BW'(N - K - 1);
   localparam logic [TW-1:0] SAMPLE_END = TW'(TS - 1);

   sar_state_e      state_q;
   logic            ph_q;
   logic [BW-1:0]   bit_q;
   logic [TW-1:0]   cnt_q;
   logic [N-1:0]    sar_q;
   logic            eoc_q;
   logic            s_clk_q;
   logic            cmp_clk_q;
   logic            cmp_clk_coarse_q;
   logic            fine_drain_q;
   logic            coarse_drain_q;

   logic [2*N-1:0]  fine_btm;
   logic [2*K-1:0]  coarse_btm;

   logic            start_c;
   logic            coarse_set_c;
   logic            fine_set_c;
   logic            handoff_c;
   logic [CW-1:0]   coarse_idx_c;

   assign start_c      = ((state_q == IDLE) || (state_q == DONE)) && bus.cnvst;
   assign coarse_set_c = (state_q == COARSE) && (ph_q == PH_A);
   assign fine_set_c   = (state_q == FINE) && (ph_q == PH_A);
   assign handoff_c    = (state_q == COARSE) && (ph_q == PH_B) && (bit_q == COARSE_LSB);
   assign coarse_idx_c = CW'(bit_q - COARSE_LSB);

   sar_btm_switch_reg #(.W(K)) u_coarse_btm (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start_c),
      .set_i       (coarse_set_c),
      .idx_i       (coarse_idx_c),
      .dec_i       (bus.cmp_out_coarse),
      .load_i      (1'b0),
      .load_mask_i ('0),
      .load_dec_i  ('0),
      .btm_o       (coarse_btm)
   );

   // The coarse decisions (N half of the coarse array) land in the fine MSBs.
   sar_btm_switch_reg #(.W(N)) u_fine_btm (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start_c),
      .set_i       (fine_set_c),
      .idx_i       (bit_q),
      .dec_i       (bus.cmp_out),
      .load_i      (handoff_c),
      .load_mask_i ({{K{1'b1}}, {(N-K){1'b0}}}),
      .load_dec_i  ({coarse_btm[K-1:0], {(N-K){1'b0}}}),
      .btm_o       (fine_btm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         ph_q             <= PH_A;
         bit_q            <= '0;
         cnt_q            <= '0;
         sar_q            <= '0;
         eoc_q            <= 1'b0;
         s_clk_q          <= 1'b0;
         cmp_clk_q        <= 1'b0;
         cmp_clk_coarse_q <= 1'b0;
         fine_drain_q     <= 1'b0;
         coarse_drain_q   <= 1'b0;
      end else begin
         eoc_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.cnvst) begin
                  state_q <= SAMPLE;
                  s_clk_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            SAMPLE: begin
               if (cnt_q == SAMPLE_END) begin
                  state_q          <= COARSE;
                  s_clk_q          <= 1'b0;
                  coarse_drain_q   <= 1'b1;
                  cmp_clk_coarse_q <= 1'b1;
                  ph_q             <= PH_A;
                  bit_q            <= MSB_IDX;
               end else begin
                  cnt_q <= cnt_q + TW'(1);
               end
            end
            COARSE: begin
               if (ph_q == PH_A) begin
                  cmp_clk_coarse_q <= 1'b0;
                  ph_q             <= PH_B;
               end else if (bit_q == COARSE_LSB) begin
                  state_q        <= FINE;
                  coarse_drain_q <= 1'b0;
                  fine_drain_q   <= 1'b1;
                  cmp_clk_q      <= 1'b1;
                  ph_q           <= PH_A;
                  bit_q          <= FINE_MSB;
               end else begin
                  bit_q            <= bit_q - BW'(1);
                  cmp_clk_coarse_q <= 1'b1;
                  ph_q             <= PH_A;
               end
            end
            FINE: begin
               if (ph_q == PH_A) begin
                  cmp_clk_q <= 1'b0;
                  ph_q      <= PH_B;
               end else if (bit_q == '0) begin
                  // Fine N half already holds every decision (coarse copied in).
                  state_q      <= DONE;
                  fine_drain_q <= 1'b0;
                  eoc_q        <= 1'b1;
                  sar_q        <= fine_btm[N-1:0];
               end else begin
                  bit_q     <= bit_q - BW'(1);
                  cmp_clk_q <= 1'b1;
                  ph_q      <= PH_A;
               end
            end
            DONE: begin
               if (bus.cnvst) begin
                  state_q <= SAMPLE;
                  s_clk_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.sar                     = sar_q;
   assign bus.eoc                     = eoc_q;
   assign bus.cmp_clk                 = cmp_clk_q;
   assign bus.cmp_clk_coarse          = cmp_clk_coarse_q;
   assign bus.s_clk                   = s_clk_q;
   assign bus.s_clk_not               = ~s_clk_q;
   assign bus.fine_btm                = fine_btm;
   assign bus.fine_btm_not            = ~fine_btm;
   assign bus.coarse_btm              = coarse_btm;
   assign bus.coarse_btm_not          = ~coarse_btm;
   assign bus.fine_switch_drain       = fine_drain_q;
   assign bus.fine_switch_drain_not   = ~fine_drain_q;
   assign bus.coarse_switch_drain     = coarse_drain_q;
   assign bus.coarse_switch_drain_not = ~coarse_drain_q;
   assign dbg_state_o                 = state_q;

endmodule

// File: tb/tb_sar_logic_cs_param.sv
// Directed bench for sar_logic_cs_param: two instances (N10/K5/TS2 and N8/K3/TS4)
// driven with hand-worked decision sequences and expected results.
module tb_sar_logic_cs_param;
   import sar_logic_pkg::*;

   localparam int CLK_P = 10;

   typedef struct {
      logic [31:0] sar, fbtm, cbtm, fbtmn, cbtmn;
      logic        eoc, sclk, sclkn, cclk, cclkc, fd, cd, fdn, cdn;
      logic [2:0]  st;
   } obs_t;

   logic       clk;
   logic       rst_a, rst_b;
   sar_state_e st_a, st_b;
   int         n_checks = 0;
   int         n_fail   = 0;
   obs_t       mo;
   time        t1, t2, tx;

   sar_logic_cs_param_if #(.N(10), .K(5)) ifa ();
   sar_logic_cs_param_if #(.N(8),  .K(3)) ifb ();

   sar_logic_cs_param #(.N(10), .K(5), .TS(2)) dut_a (
      .clk(clk), .rst(rst_a), .bus(ifa), .dbg_state_o(st_a)
   );
   sar_logic_cs_param #(.N(8), .K(3), .TS(4)) dut_b (
      .clk(clk), .rst(rst_b), .bus(ifb), .dbg_state_o(st_b)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #(CLK_P/2) clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic obs_t get_obs(input int sel);
      obs_t o;
      if (sel == 0) begin
         o.sar = 32'(ifa.sar);        o.fbtm = 32'(ifa.fine_btm);  o.cbtm = 32'(ifa.coarse_btm);
         o.fbtmn = 32'(ifa.fine_btm_not); o.cbtmn = 32'(ifa.coarse_btm_not);
         o.eoc = ifa.eoc;  o.sclk = ifa.s_clk;  o.sclkn = ifa.s_clk_not;
         o.cclk = ifa.cmp_clk;  o.cclkc = ifa.cmp_clk_coarse;
         o.fd = ifa.fine_switch_drain;  o.cd = ifa.coarse_switch_drain;
         o.fdn = ifa.fine_switch_drain_not;  o.cdn = ifa.coarse_switch_drain_not;
         o.st = st_a;
      end else begin
         o.sar = 32'(ifb.sar);        o.fbtm = 32'(ifb.fine_btm);  o.cbtm = 32'(ifb.coarse_btm);
         o.fbtmn = 32'(ifb.fine_btm_not); o.cbtmn = 32'(ifb.coarse_btm_not);
         o.eoc = ifb.eoc;  o.sclk = ifb.s_clk;  o.sclkn = ifb.s_clk_not;
         o.cclk = ifb.cmp_clk;  o.cclkc = ifb.cmp_clk_coarse;
         o.fd = ifb.fine_switch_drain;  o.cd = ifb.coarse_switch_drain;
         o.fdn = ifb.fine_switch_drain_not;  o.cdn = ifb.coarse_switch_drain_not;
         o.st = st_b;
      end
      return o;
   endfunction

   // Complements and drain exclusivity hold in every cycle on both instances.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         logic [31:0] fall, call;
         fall = (s == 0) ? 32'hF_FFFF : 32'hFFFF;
         call = (s == 0) ? 32'h3FF : 32'h3F;
         mo = get_obs(s);
         check("s_clk_not", {31'b0, mo.sclkn}, {31'b0, ~mo.sclk});
         check("fine_btm_not", mo.fbtmn, ~mo.fbtm & fall);
         check("coarse_btm_not", mo.cbtmn, ~mo.cbtm & call);
         check("fine_drain_not", {31'b0, mo.fdn}, {31'b0, ~mo.fd});
         check("coarse_drain_not", {31'b0, mo.cdn}, {31'b0, ~mo.cd});
         check("drain_excl", {31'b0, mo.fd & mo.cd}, 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input int sel, input logic cn, input logic cc, input logic cf);
      if (sel == 0) begin
         ifa.cnvst = cn;  ifa.cmp_out_coarse = cc;  ifa.cmp_out = cf;
      end else begin
         ifb.cnvst = cn;  ifb.cmp_out_coarse = cc;  ifb.cmp_out = cf;
      end
   endtask

   task automatic check_reset(input int sel);
      obs_t o;
      logic [31:0] fall, call;
      fall = (sel == 0) ? 32'hF_FFFF : 32'hFFFF;
      call = (sel == 0) ? 32'h3FF : 32'h3F;
      o = get_obs(sel);
      check("rst_state", 32'(o.st), 32'(IDLE));
      check("rst_sar", o.sar, 32'd0);
      check("rst_eoc", {31'b0, o.eoc}, 32'd0);
      check("rst_cmp_clk", {31'b0, o.cclk}, 32'd0);
      check("rst_cmp_clk_coarse", {31'b0, o.cclkc}, 32'd0);
      check("rst_s_clk", {31'b0, o.sclk}, 32'd0);
      check("rst_fine_btm", o.fbtm, 32'd0);
      check("rst_coarse_btm", o.cbtm, 32'd0);
      check("rst_drains", {30'b0, o.fd, o.cd}, 32'd0);
      check("rst_nots_1b", {29'b0, o.sclkn, o.fdn, o.cdn}, 32'd7);
      check("rst_fine_btm_not", o.fbtmn, fall);
      check("rst_coarse_btm_not", o.cbtmn, call);
   endtask

   // One conversion starting at the next rising edge (E0). Decisions for bit b are
   // cseq[b] on the coarse comparator and fseq[b] on the fine one; in every other
   // cycle comparators and cnvst carry random values that must be ignored.
   task automatic conv(input int sel, input logic [15:0] cseq, input logic [15:0] fseq,
                       input logic [15:0] exp_sar, input logic [15:0] old_sar,
                       input logic hold, input int abort_k, output time t_eoc);
      int n, kk, ts, last, b;
      obs_t o;
      logic [31:0] es, fm, um, exp_fb, exp_fb_up, exp_cb;
      n    = (sel == 0) ? 10 : 8;
      kk   = (sel == 0) ? 5 : 3;
      ts   = (sel == 0) ? 2 : 4;
      last = ts + 2*n;
      es   = 32'(exp_sar);
      fm   = (32'd1 << n) - 32'd1;
      um   = fm & ~((32'd1 << (n - kk)) - 32'd1);
      exp_fb    = ((~es & fm) << n) | (es & fm);
      exp_fb_up = ((~es & um) << n) | (es & um);
      exp_cb    = (((~es & um) >> (n - kk)) << kk) | ((es & um) >> (n - kk));
      t_eoc = 0;
      drive(sel, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         if (k == abort_k) begin
            rst_a = 1'b1;
            #1;
            check_reset(0);
            drive(sel, 1'b0, 1'b0, 1'b0);
            return;
         end
         o = get_obs(sel);
         check("eoc", {31'b0, o.eoc}, {31'b0, k == last});
         check("sar", o.sar, (k == last) ? es : 32'(old_sar));
         check("s_clk", {31'b0, o.sclk}, {31'b0, k < ts});
         check("coarse_drain", {31'b0, o.cd}, {31'b0, (k >= ts) && (k < ts + 2*kk)});
         check("fine_drain", {31'b0, o.fd}, {31'b0, (k >= ts + 2*kk) && (k < last)});
         check("cmp_clk_coarse", {31'b0, o.cclkc},
               {31'b0, (k >= ts) && (k < ts + 2*kk) && ((k - ts) % 2 == 0)});
         check("cmp_clk", {31'b0, o.cclk},
               {31'b0, (k >= ts + 2*kk) && (k < last) && ((k - ts) % 2 == 0)});
         if (k < ts) begin
            check("sample_fine_btm", o.fbtm, 32'd0);
            check("sample_coarse_btm", o.cbtm, 32'd0);
         end
         if (k == ts + 2*kk) begin
            check("handoff_fine_btm", o.fbtm, exp_fb_up);
            check("handoff_coarse_btm", o.cbtm, exp_cb);
         end
         if (k == last) begin
            check("done_fine_btm", o.fbtm, exp_fb);
            t_eoc = $time;
            drive(sel, hold, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else if ((k >= ts) && ((k - ts) % 2 == 0)) begin
            b = n - 1 - (k - ts) / 2;
            drive(sel, 1'($urandom_range(0, 1)), cseq[b], fseq[b]);
         end else begin
            drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0);
      drive(1, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst_a = 1'b0;
      rst_b = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("idle_hold_state", 32'(st_a), 32'(IDLE));
      end

      // All-ones coarse, all-zeros fine.
      conv(0, 16'h3FF, 16'h000, 16'h3E0, 16'h000, 1'b0, -1, tx);
      repeat (3) begin
         @(negedge clk);
         check("idle_after_done", 32'(st_a), 32'(IDLE));
         check("idle_eoc", {31'b0, ifa.eoc}, 32'd0);
      end

      // Alternating decisions, then a back-to-back conversion.
      conv(0, 16'h2AA, 16'h2AA, 16'h2AA, 16'h3E0, 1'b1, -1, t1);
      conv(0, 16'h155, 16'h0F0, 16'h150, 16'h2AA, 1'b0, -1, t2);
      check("eoc_period_a", 32'((t2 - t1) / CLK_P), 32'd23);

      // Reset during FINE bit 2 (k = 2 + 2*7).
      conv(0, 16'h3FF, 16'h3FF, 16'h3FF, 16'h150, 1'b0, 16, tx);
      @(negedge clk);
      check_reset(0);
      rst_a = 1'b0;
      repeat (30) begin
         @(negedge clk);
         check("no_eoc_after_abort", {31'b0, ifa.eoc}, 32'd0);
         check("sar_after_abort", 32'(ifa.sar), 32'd0);
      end
      conv(0, 16'h327, 16'h327, 16'h327, 16'h000, 1'b0, -1, tx);

      // Second parameter set.
      conv(1, 16'h0A5, 16'h05A, 16'h0BA, 16'h000, 1'b1, -1, t1);
      conv(1, 16'h000, 16'h0FF, 16'h01F, 16'h0BA, 1'b0, -1, t2);
      check("eoc_period_b", 32'((t2 - t1) / CLK_P), 32'd21);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
